// File: rtl/nibble_seq_pkg.sv
// rtl/nibble_seq_pkg.sv - shared types and constants for the nibble add/subtract sequencer
package nibble_seq_pkg;

    localparam int NIB_W = 4;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/nibble_slice.sv
// rtl/nibble_slice.sv - combinational 4-bit ripple-carry adder slice
// NIBSEQ_OVF_EN adds the c3 port (carry into bit 3) for signed-overflow detection.
module nibble_slice
    import nibble_seq_pkg::*;
(
    input  logic [NIB_W-1:0] in1,
    input  logic [NIB_W-1:0] in2,
    input  logic             cin,
    output logic [NIB_W-1:0] sum,
`ifdef NIBSEQ_OVF_EN
    output logic             c3,
`endif
    output logic             cout
);

    logic [NIB_W:0] carry;

    always_comb begin
        sum      = '0;
        carry    = '0;
        carry[0] = cin;
        for (int i = 0; i < NIB_W; i++) begin
            sum[i]     = in1[i] ^ in2[i] ^ carry[i];
            carry[i+1] = (in1[i] & in2[i]) | (carry[i] & (in1[i] ^ in2[i]));
        end
    end

    assign cout = carry[NIB_W];
`ifdef NIBSEQ_OVF_EN
    assign c3 = carry[NIB_W-1];
`endif

endmodule

// File: rtl/nibble_add_seq.sv
// rtl/nibble_add_seq.sv - WIDTH-bit add/subtract sequenced one nibble per clock, LSB first
// NIBSEQ_OVF_EN enables signed-overflow reporting on ovf; otherwise ovf stays 0.
module nibble_add_seq
    import nibble_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf
);

    localparam int NIB = WIDTH / NIB_W;
    localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IW-1:0] LAST = IW'(NIB - 1);

    state_t           state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] work;
    logic             op_reg;
    logic [IW-1:0]    idx;
    logic             carry;

    logic [NIB_W-1:0] a_nib [NIB];
    logic [NIB_W-1:0] b_nib [NIB];
    logic [NIB_W-1:0] in2;
    logic [NIB_W-1:0] s_sum;
    logic             s_cout;
    logic             ovf_bit;
    logic [WIDTH-1:0] work_next;

    for (genvar n = 0; n < NIB; n++) begin : g_nib
        assign a_nib[n] = a_reg[n*NIB_W +: NIB_W];
        assign b_nib[n] = b_reg[n*NIB_W +: NIB_W];
    end

    assign in2 = (op_reg == OP_ADD) ? b_nib[idx] : ~b_nib[idx];

`ifdef NIBSEQ_OVF_EN
    logic s_c3;

    nibble_slice u_slice (
        .in1  (a_nib[idx]),
        .in2  (in2),
        .cin  (carry),
        .sum  (s_sum),
        .c3   (s_c3),
        .cout (s_cout)
    );

    assign ovf_bit = s_c3 ^ s_cout;
`else
    nibble_slice u_slice (
        .in1  (a_nib[idx]),
        .in2  (in2),
        .cin  (carry),
        .sum  (s_sum),
        .cout (s_cout)
    );

    assign ovf_bit = 1'b0;
`endif

    // New nibble enters at the top; after NIB shifts the LSB nibble sits at the bottom.
    if (NIB > 1) begin : g_shift
        assign work_next = {s_sum, work[WIDTH-1:NIB_W]};
    end else begin : g_single
        assign work_next = s_sum;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            a_reg  <= '0;
            b_reg  <= '0;
            op_reg <= 1'b0;
            idx    <= '0;
            carry  <= 1'b0;
            work   <= '0;
            result <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg  <= a;
                        b_reg  <= b;
                        op_reg <= op;
                        idx    <= '0;
                        carry  <= (op == OP_SUB);
                        state  <= RUN;
                    end
                end
                RUN: begin
                    work  <= work_next;
                    carry <= s_cout;
                    idx   <= idx + IW'(1);
                    if (idx == LAST) begin
                        result <= work_next;
                        cout   <= s_cout;
                        ovf    <= ovf_bit;
                        state  <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_nibble_add_seq.sv
// tb/tb_nibble_add_seq.sv - randomized self-checking bench for nibble_add_seq at WIDTH 8 and 16
module tb_nibble_add_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start8 = 1'b0, op8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        busy8, done8, cout8, ovf8;
    logic [7:0]  result8;
    logic        start16 = 1'b0, op16 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0;
    logic        busy16, done16, cout16, ovf16;
    logic [15:0] result16;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    nibble_add_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .op(op8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .result(result8), .cout(cout8), .ovf(ovf8)
    );

    nibble_add_seq #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .op(op16), .a(a16), .b(b16),
        .busy(busy16), .done(done16), .result(result16), .cout(cout16), .ovf(ovf16)
    );

    // Reference: plain modular arithmetic on integers, sign rules for overflow.
    function automatic void model(input int w, input int av, input int bv, input bit opv,
                                  output int r, output bit c, output bit v);
        int mask, sum, sa, sb, sr;
        mask = (1 << w) - 1;
        av = av & mask;
        bv = bv & mask;
        sum = opv ? (av + ((~bv) & mask) + 1) : (av + bv);
        r = sum & mask;
        c = bit'((sum >> w) & 1);
        sa = (av >> (w - 1)) & 1;
        sb = (bv >> (w - 1)) & 1;
        sr = (r >> (w - 1)) & 1;
`ifdef NIBSEQ_OVF_EN
        v = opv ? ((sa != sb) && (sr != sa)) : ((sa == sb) && (sr != sa));
`else
        v = 1'b0;
`endif
    endfunction

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (busy8 !== 1'b0)    begin bad++; $display("FAIL reset_busy8 got=%b exp=0", busy8); end
        total++; if (done8 !== 1'b0)    begin bad++; $display("FAIL reset_done8 got=%b exp=0", done8); end
        total++; if (result8 !== 8'h00) begin bad++; $display("FAIL reset_result8 got=%h exp=00", result8); end
        total++; if (cout8 !== 1'b0)    begin bad++; $display("FAIL reset_cout8 got=%b exp=0", cout8); end
        total++; if (ovf8 !== 1'b0)     begin bad++; $display("FAIL reset_ovf8 got=%b exp=0", ovf8); end
        total++; if (result16 !== 16'h0 || busy16 !== 1'b0 || done16 !== 1'b0)
            begin bad++; $display("FAIL reset_dut16 got=%h/%b/%b exp=0/0/0", result16, busy16, done16); end
        rst = 1'b0;
    endtask

    // Called at a negedge with dut8 idle; returns at a negedge with dut8 idle again.
    task automatic run_op8(input logic [7:0] av, input logic [7:0] bv, input logic opv, input string name);
        int r, n, busy_n;
        bit c, v;
        model(8, int'(av), int'(bv), opv, r, c, v);
        start8 = 1'b1; a8 = av; b8 = bv; op8 = opv;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0; a8 = ~av; b8 = ~bv; op8 = ~opv;
        n = 1; busy_n = 0;
        while (done8 !== 1'b1 && n < 20) begin
            if (busy8 === 1'b1) busy_n++;
            @(negedge clk);
            n++;
        end
        total++;
        if (done8 !== 1'b1) begin bad++; $display("FAIL %s_timeout got=no_done exp=done", name); end
        else if (n - 1 !== 2) begin bad++; $display("FAIL %s_latency got=%0d exp=2", name, n - 1); end
        total++; if (busy_n !== 2)      begin bad++; $display("FAIL %s_busy_cycles got=%0d exp=2", name, busy_n); end
        total++; if (busy8 !== 1'b0)    begin bad++; $display("FAIL %s_busy_in_done got=%b exp=0", name, busy8); end
        total++; if (result8 !== r[7:0]) begin bad++; $display("FAIL %s_result got=%h exp=%h", name, result8, r[7:0]); end
        total++; if (cout8 !== c)       begin bad++; $display("FAIL %s_cout got=%b exp=%b", name, cout8, c); end
        total++; if (ovf8 !== v)        begin bad++; $display("FAIL %s_ovf got=%b exp=%b", name, ovf8, v); end
        @(negedge clk);
        total++; if (done8 !== 1'b0)    begin bad++; $display("FAIL %s_done_pulse got=%b exp=0", name, done8); end
        total++; if (result8 !== r[7:0]) begin bad++; $display("FAIL %s_hold got=%h exp=%h", name, result8, r[7:0]); end
    endtask

    task automatic test_directed;
        run_op8(8'h3C, 8'h45, 1'b0, "add_3c_45");
        run_op8(8'h10, 8'h01, 1'b1, "sub_10_01");
        run_op8(8'h01, 8'h02, 1'b1, "sub_01_02");
        run_op8(8'hFF, 8'h01, 1'b0, "add_ff_01");
        run_op8(8'h7F, 8'h01, 1'b0, "add_7f_01");
        run_op8(8'h80, 8'h01, 1'b1, "sub_80_01");
        run_op8(8'h00, 8'h00, 1'b1, "sub_00_00");
    endtask

    task automatic test_random;
        for (int i = 0; i < 24; i++)
            run_op8(8'($urandom), 8'($urandom), 1'($urandom), "rand8");
    endtask

    task automatic test_back_to_back;
        int q[$];
        int r, last;
        bit c, v, exp_done;
        last = -1;
        for (int j = 0; j < 24; j++) begin
            start8 = 1'b1; a8 = 8'($urandom); b8 = 8'($urandom); op8 = 1'($urandom);
            if (j % 4 == 0) begin
                model(8, int'(a8), int'(b8), op8, r, c, v);
                q.push_back(r);
            end
            @(posedge clk);
            @(negedge clk);
            exp_done = (j >= 2) && ((j - 2) % 4 == 0);
            total++; if (done8 !== exp_done) begin bad++; $display("FAIL b2b_done_at_%0d got=%b exp=%b", j, done8, exp_done); end
            if (exp_done && q.size() > 0) begin
                last = q.pop_front();
                total++; if (result8 !== last[7:0]) begin bad++; $display("FAIL b2b_result_at_%0d got=%h exp=%h", j, result8, last[7:0]); end
            end else if (last >= 0) begin
                total++; if (result8 !== last[7:0]) begin bad++; $display("FAIL b2b_stable_at_%0d got=%h exp=%h", j, result8, last[7:0]); end
            end
        end
        start8 = 1'b0;
    endtask

    task automatic test_reset_mid;
        int seen;
        start8 = 1'b1; a8 = 8'h3C; b8 = 8'h45; op8 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        total++; if (busy8 !== 1'b1) begin bad++; $display("FAIL mid_busy_before got=%b exp=1", busy8); end
        #2 rst = 1'b1;
        #1;
        total++; if (busy8 !== 1'b0 || done8 !== 1'b0)
            begin bad++; $display("FAIL mid_async_ctrl got=%b/%b exp=0/0", busy8, done8); end
        total++; if (result8 !== 8'h00 || cout8 !== 1'b0 || ovf8 !== 1'b0)
            begin bad++; $display("FAIL mid_async_out got=%h/%b/%b exp=00/0/0", result8, cout8, ovf8); end
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (done8 === 1'b1) seen++;
        end
        total++; if (seen !== 0) begin bad++; $display("FAIL mid_no_done got=%0d exp=0", seen); end
        rst = 1'b0;
        run_op8(8'h3C, 8'h45, 1'b0, "after_reset");
    endtask

    task automatic run_op16(input logic [15:0] av, input logic [15:0] bv, input logic opv, input string name);
        int r, n;
        bit c, v;
        model(16, int'(av), int'(bv), opv, r, c, v);
        start16 = 1'b1; a16 = av; b16 = bv; op16 = opv;
        @(posedge clk);
        @(negedge clk);
        start16 = 1'b0;
        n = 1;
        while (done16 !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (done16 !== 1'b1) begin bad++; $display("FAIL %s_timeout got=no_done exp=done", name); end
        else if (n - 1 !== 4) begin bad++; $display("FAIL %s_latency got=%0d exp=4", name, n - 1); end
        total++; if (result16 !== r[15:0]) begin bad++; $display("FAIL %s_result got=%h exp=%h", name, result16, r[15:0]); end
        total++; if (cout16 !== c || ovf16 !== v)
            begin bad++; $display("FAIL %s_flags got=%b%b exp=%b%b", name, cout16, ovf16, c, v); end
        @(negedge clk);
    endtask

    task automatic test_width16;
        run_op16(16'h1234, 16'h0FCD, 1'b0, "w16_add");
        run_op16(16'h8000, 16'h0001, 1'b1, "w16_sub");
        for (int i = 0; i < 8; i++)
            run_op16(16'($urandom), 16'($urandom), 1'($urandom), "w16_rand");
    endtask

    initial begin
        @(negedge clk);
        test_reset;
        test_directed;
        test_random;
        test_back_to_back;
        test_reset_mid;
        test_width16;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/nibble_add_seq.md
# nibble_add_seq

Multi-cycle sequencer that performs WIDTH-bit add/subtract by time-multiplexing a single 4-bit ripple-carry adder slice, one nibble per clock, LSB nibble first. It owns the operand and carry registers and the start/done handshake. It sits between the ALU control path and a narrow adder, trading latency for area.

## Interface
- WIDTH, 8: operand/result width in bits. Must be a multiple of 4 and at least 4. NIB = WIDTH/4.
- clk  input  1  sole clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high; clears all state.
- start  input  1  request; sampled only in IDLE.
- op  input  1  0 = add (a+b), 1 = subtract (a-b); sampled with start.
- a  input  WIDTH  operand A; sampled with start.
- b  input  WIDTH  operand B; sampled with start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when result is valid.
- result  output  WIDTH  registered sum/difference.
- cout  output  1  carry out of the MSB nibble; for subtract, 1 = no borrow.
- ovf  output  1  signed overflow (see Configuration).

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: if start=1, capture a, b, op; set nibble index idx=0; set carry reg = op; go to RUN. Otherwise stay.
- RUN: the slice adds a[idx] and (op ? ~b[idx] : b[idx]) with carry reg. Sum nibble goes into the working shift register and the carry reg updates. idx increments.
  - If idx = NIB-1, copy the working value to result and the final carry to cout, update ovf, and go to DONE.
- DONE: done=1 for this cycle only; go to IDLE on the next edge.
- start in RUN or DONE is ignored. No queueing.
- result, cout and ovf change only on entry to DONE. They hold until the next completion, including across IDLE and the next RUN.
- Arithmetic is modulo 2^WIDTH. Subtract is a + ~b + 1. The operand registers are not modified by the result path.

## Timing
- Reset values: state=IDLE, busy=0, done=0, result=0, cout=0, ovf=0, idx=0, carry reg=0, operand regs=0.
- Let edge E0 be the edge that samples start=1 in IDLE. Nibble k is computed on edge E(k+1).
- Edge E(NIB) enters DONE, so done is high during the cycle after E(NIB).
  - Latency is NIB cycles from E0 to done. For WIDTH=8, done is high 2 cycles after E0.
- busy is high from just after E0 through E(NIB). It is low in DONE.
- The earliest next start is accepted at the edge after DONE, giving a throughput of one operation per NIB+2 cycles.
- rst asserted mid-operation: state goes to IDLE immediately (asynchronously) and outputs take their reset values. There is no done pulse for the aborted operation.
- rst released on the same edge that start is high: start is not sampled on that edge.

## Configuration
- NIBSEQ_OVF_EN defined: ovf is set on DONE entry to (carry into MSB bit) XOR (carry out of MSB bit).
  - This needs the slice to expose its internal bit-2→3 carry.
- NIBSEQ_OVF_EN undefined: ovf is tied to 0 and the extra carry tap is not built.

## Structure
- Shared package nibble_seq_pkg holds:
  - the FSM state typedef (IDLE, RUN, DONE);
  - constant NIB_W=4;
  - the op encodings OP_ADD=0 and OP_SUB=1.
- One sub-module, nibble_slice: a combinational 4-bit ripple adder with in1, in2, cin, sum, cout, and c3, the carry into bit 3. c3 is used only when NIBSEQ_OVF_EN is defined.
- Index counter width is $clog2(NIB), with a minimum of 1.

## Test plan
- WIDTH=8, add 0x3C+0x45 → result=0x81, cout=0, ovf=1 (if _EN), done exactly 2 cycles after E0, busy high for 2 cycles.
- Subtract 0x10-0x01 → result=0x0F, cout=1, ovf=0. Subtract 0x01-0x02 → result=0xFF, cout=0.
- Add 0xFF+0x01 → result=0x00, cout=1, ovf=0. Add 0x7F+0x01 → result=0x80, ovf=1 (0 when macro undefined).
- Hold start=1 continuously with different operands changing each cycle → only operands present at IDLE edges are used; done pulses every 4 cycles; result is stable between pulses.
- Assert rst one cycle into RUN → busy, done, result and cout go to 0 immediately; no done pulse. A new start after release completes normally.
- WIDTH=16, add 0x1234+0x0FCD → result=0x2201, done 4 cycles after E0.
